// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_queue
// Description : RV32I fetch front end. Owns the fetch PC, issues pipelined
//               imem reads and buffers {pc, inst} pairs in a DEPTH-entry FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    output logic            proto_err
);

    localparam int unsigned     c_PTR_W = $clog2(DEPTH);
    localparam int unsigned     c_CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned     c_OUT_W = $clog2(MAX_OUTST + 1);
    localparam int unsigned     c_SUM_W = ((c_CNT_W > c_OUT_W) ? c_CNT_W : c_OUT_W) + 1;
    localparam logic [XLEN-1:0] c_WORD  = XLEN'(4);
    localparam logic [XLEN-1:0] c_ALIGN = ~XLEN'(3);

    logic [XLEN-1:0]    fpc_q, fpc_d;
    logic [XLEN-1:0]    rpc_q, rpc_d;
    logic [c_OUT_W-1:0] outst_q, outst_d;
    logic [c_OUT_W-1:0] discard_q, discard_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [c_PTR_W-1:0] wptr_q, wptr_d;
    logic [c_PTR_W-1:0] rptr_q, rptr_d;
    logic               proto_err_q, proto_err_d;
    logic [XLEN-1:0]    data_q [DEPTH];
    logic [XLEN-1:0]    pc_q   [DEPTH];

    logic [c_OUT_W-1:0] w_live;
    logic [c_SUM_W-1:0] w_fill;
    logic               w_req;
    logic               w_grant;
    logic               w_resp;
    logic               w_stray;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;

    // Queue slots are reserved at issue time: entries held plus live requests.
    assign w_live  = outst_q - discard_q;
    assign w_fill  = c_SUM_W'(count_q) + c_SUM_W'(w_live);
    assign w_req   = reset & ~redirect_valid & (w_fill < c_SUM_W'(DEPTH))
                   & (outst_q < c_OUT_W'(MAX_OUTST));
    assign w_grant = w_req & imem_gnt;
    assign w_resp  = reset & imem_rvalid & (outst_q != '0);
    assign w_stray = reset & imem_rvalid & (outst_q == '0);
    assign w_valid = reset & (count_q != '0);
    assign w_pop   = w_valid & inst_ready & ~redirect_valid;
    assign w_push  = w_resp & ~redirect_valid & (discard_q == '0);

    always_comb begin
        fpc_d       = fpc_q;
        rpc_d       = rpc_q;
        outst_d     = outst_q;
        discard_d   = discard_q;
        count_d     = count_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        proto_err_d = proto_err_q | w_stray;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            fpc_d     = redirect_pc & c_ALIGN;
            rpc_d     = redirect_pc & c_ALIGN;
            outst_d   = outst_q - c_OUT_W'(w_resp);
            discard_d = outst_q - c_OUT_W'(w_resp);
            count_d   = '0;
            wptr_d    = '0;
            rptr_d    = '0;
        end else begin
            if (w_grant) begin
                fpc_d = fpc_q + c_WORD;
            end
            outst_d = outst_q + c_OUT_W'(w_grant) - c_OUT_W'(w_resp);
            if (w_resp && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (w_push) begin
                rpc_d  = rpc_q + c_WORD;
                wptr_d = wptr_q + 1'b1;
            end
            if (w_pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fpc_q       <= RESET_PC;
            rpc_q       <= RESET_PC;
            outst_q     <= '0;
            discard_q   <= '0;
            count_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            fpc_q       <= fpc_d;
            rpc_q       <= rpc_d;
            outst_q     <= outst_d;
            discard_q   <= discard_d;
            count_q     <= count_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            data_q[wptr_q] <= imem_rdata;
            pc_q[wptr_q]   <= rpc_q;
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = reset ? fpc_q : '0;
    assign inst_valid = w_valid;
    assign inst_data  = w_valid ? data_q[rptr_q] : '0;
    assign inst_pc    = w_valid ? pc_q[rptr_q] : '0;
    assign proto_err  = reset & proto_err_q;

endmodule
`default_nettype wire
